// File: rtl/pitch_jump_pkg.sv
// Shared types and helpers for the pitch jump detector.
package pitch_jump_pkg;

  // Metric select applied at each window end.
  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  // Decision state: free to fire, or suppressing jumps after one.
  typedef enum logic {
    ST_ACCUM    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_e;

  // Right-shift a value and clamp it to the largest number that fits in 'width' bits.
  function automatic logic [31:0] sat_shift(input logic [31:0] val,
                                            input int unsigned shift,
                                            input int unsigned width);
    logic [31:0] shifted;
    logic [31:0] limit;
    shifted = val >> shift;
    limit   = (32'd1 << width) - 32'd1;
    return (shifted > limit) ? limit : shifted;
  endfunction

endpackage

// File: rtl/pjd_window_acc.sv
// Per-window frame statistics: frame counter, voiced counter, bin sum and
// bin maximum. The *_next outputs already include the frame being accepted
// this cycle so the decision at the window-end edge sees the full window.
module pjd_window_acc
  import pitch_jump_pkg::*;
#(
  parameter int LGFFT     = 10,
  parameter int LGWIN     = 7,
  parameter int MAG_W     = 16,
  parameter int MAGTHRESH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [LGFFT-2:0]         i_data,
  input  logic [MAG_W-1:0]         i_mag,
  output logic                     win_end,
  output logic [LGWIN:0]           voiced_next,
  output logic [LGFFT-2+LGWIN:0]   acc_next,
  output logic [LGFFT-2:0]         max_next
);

  localparam int BIN_W = LGFFT - 1;
  localparam int ACC_W = BIN_W + LGWIN;
  localparam int VCN_W = LGWIN + 1;

  logic [LGWIN-1:0] frame_r;
  logic [VCN_W-1:0] voiced_r;
  logic [ACC_W-1:0] acc_r;
  logic [BIN_W-1:0] max_r;
  logic             voiced_s;

  // Classify the current frame and form the statistics including it.
  always_comb begin
    voiced_s    = (i_mag >= MAG_W'(MAGTHRESH));
    win_end     = i_valid && (&frame_r);
    voiced_next = voiced_r;
    acc_next    = acc_r;
    max_next    = max_r;
    if (i_valid && voiced_s) begin
      voiced_next = voiced_r + VCN_W'(1'b1);
      acc_next    = acc_r + ACC_W'(i_data);
      max_next    = (i_data > max_r) ? i_data : max_r;
    end else begin
      voiced_next = voiced_r;
    end
  end

  // Advance the statistics on each frame; start fresh once a window completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_r  <= {LGWIN{1'b0}};
      voiced_r <= {VCN_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      max_r    <= {BIN_W{1'b0}};
    end else if (win_end) begin
      frame_r  <= {LGWIN{1'b0}};
      voiced_r <= {VCN_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      max_r    <= {BIN_W{1'b0}};
    end else if (i_valid) begin
      frame_r  <= frame_r + LGWIN'(1'b1);
      voiced_r <= voiced_next;
      acc_r    <= acc_next;
      max_r    <= max_next;
    end else begin
      frame_r  <= frame_r;
    end
  end

endmodule

// File: rtl/pitch_jump_detector.sv
// Pitch jump detector: decides once per window of frames whether a sustained
// pitch was voiced and, if so, pulses 'jump' with a quantised height.
// Optional build macro PJD_HOLD_HEIGHT_EN: when defined, 'height' keeps the
// last jump value until the next jump or reset; otherwise it is non-zero only
// during the jump cycle.
module pitch_jump_detector
  import pitch_jump_pkg::*;
#(
  parameter int FFT         = 1024,
  parameter int HFFT        = FFT / 2,
  parameter int LGFFT       = 10,
  parameter int LGWIN       = 7,
  parameter int COUNTTHRESH = 100,
  parameter int ACCUTHRESH  = 32,
  parameter int MAG_W       = 16,
  parameter int MAGTHRESH   = 1024,
  parameter int HEIGHT_W    = 5,
  parameter int HSHIFT      = 3,
  parameter int COOLDOWN    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [LGFFT-2:0]    i_data,
  input  logic [MAG_W-1:0]    i_mag,
  input  logic                i_mode,
  output logic                jump,
  output logic [HEIGHT_W-1:0] height,
  output logic                o_busy
);

  localparam int BIN_W = $clog2(HFFT);
  localparam int ACC_W = BIN_W + LGWIN;
  localparam int VCN_W = LGWIN + 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic                win_end_s;
  logic [VCN_W-1:0]    voiced_next_s;
  logic [ACC_W-1:0]    acc_next_s;
  logic [BIN_W-1:0]    max_next_s;
  logic [BIN_W-1:0]    metric_s;
  logic                qualify_s;
  logic [HEIGHT_W-1:0] height_calc_s;

  state_e              state_r, state_n;
  logic [CD_W-1:0]     cd_cnt_r, cd_cnt_n;
  logic                jump_r, jump_n;
  logic [HEIGHT_W-1:0] height_r, height_n;
  logic                busy_r, busy_n;

  pjd_window_acc #(
    .LGFFT     (LGFFT),
    .LGWIN     (LGWIN),
    .MAG_W     (MAG_W),
    .MAGTHRESH (MAGTHRESH)
  ) u_win (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_mag       (i_mag),
    .win_end     (win_end_s),
    .voiced_next (voiced_next_s),
    .acc_next    (acc_next_s),
    .max_next    (max_next_s)
  );

  // Window metric, qualification and saturated height from the end-of-window statistics.
  always_comb begin
    if (mode_e'(i_mode) == MODE_AVG) begin
      metric_s = BIN_W'(acc_next_s >> LGWIN);
    end else begin
      metric_s = max_next_s;
    end
    qualify_s     = (32'(voiced_next_s) >= 32'(COUNTTHRESH)) &&
                    (32'(metric_s) >= 32'(ACCUTHRESH));
    height_calc_s = HEIGHT_W'(sat_shift(32'(metric_s) - 32'(ACCUTHRESH), HSHIFT, HEIGHT_W));
  end

  // Next-state and output decisions; only window ends move the machine.
  always_comb begin
    state_n  = state_r;
    cd_cnt_n = cd_cnt_r;
    jump_n   = 1'b0;
`ifdef PJD_HOLD_HEIGHT_EN
    height_n = height_r;
`else
    height_n = {HEIGHT_W{1'b0}};
`endif
    if (win_end_s) begin
      case (state_r)
        ST_ACCUM: begin
          if (qualify_s) begin
            jump_n   = 1'b1;
            height_n = height_calc_s;
            if (COOLDOWN > 0) begin
              state_n  = ST_COOLDOWN;
              cd_cnt_n = CD_W'(COOLDOWN);
            end else begin
              state_n  = ST_ACCUM;
            end
          end else begin
            state_n = ST_ACCUM;
          end
        end
        ST_COOLDOWN: begin
          if (cd_cnt_r <= CD_W'(1'b1)) begin
            state_n  = ST_ACCUM;
            cd_cnt_n = {CD_W{1'b0}};
          end else begin
            cd_cnt_n = cd_cnt_r - CD_W'(1'b1);
          end
        end
        default: begin
          state_n  = ST_ACCUM;
          cd_cnt_n = {CD_W{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
    busy_n = (state_n == ST_COOLDOWN);
  end

  // State, cooldown counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_ACCUM;
      cd_cnt_r <= {CD_W{1'b0}};
      jump_r   <= 1'b0;
      height_r <= {HEIGHT_W{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      cd_cnt_r <= cd_cnt_n;
      jump_r   <= jump_n;
      height_r <= height_n;
      busy_r   <= busy_n;
    end
  end

  assign jump   = jump_r;
  assign height = height_r;
  assign o_busy = busy_r;

endmodule

// File: tb/tb_pitch_jump_detector.sv
// Scoreboard bench for pitch_jump_detector: the driver pushes the expected
// outputs for each window-end edge and the following cycle; the monitor pops
// and compares on those cycles and on any jump pulse.
module tb_pitch_jump_detector;

`ifdef PJD_HOLD_HEIGHT_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic       jump;
    logic [4:0] height;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic [8:0] i_data = 9'd0;
  logic [15:0] i_mag = 16'd0;
  logic       i_mode = 1'b0;
  logic       jump;
  logic [4:0] height;
  logic       o_busy;

  logic       chk_s = 1'b0;
  logic       chk_d = 1'b0;
  logic [4:0] last_h = 5'd0;
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  pitch_jump_detector dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_mag   (i_mag),
    .i_mode  (i_mode),
    .jump    (jump),
    .height  (height),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got jump/height/busy=%b required %b", name, act, req);
    end
  endtask

  // Monitor: compare on announced window-end cycles and on every jump pulse.
  always @(negedge clk) begin
    exp_t e;
    if (chk_d || jump) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got jump=%0b height=%0d busy=%0b required no event", jump, height, o_busy);
      end else begin
        e = q.pop_front();
        check("window", {jump, height, o_busy}, {e.jump, e.height, e.busy});
      end
    end
    chk_d = chk_s;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    chk_s = 1'b0; i_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_outputs", {jump, height, o_busy}, 7'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    last_h = 5'd0;
  endtask

  // Unchecked frames (partial window); every frame voiced.
  task automatic frames(input logic [8:0] bin, input int n, input int gap);
    for (int f = 0; f < n; f++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_data = bin; i_mag = 16'd2000;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        i_valid = 1'b0;
      end
    end
  endtask

  // One full window: nv voiced frames then unvoiced ones, all of bin 'bin'.
  task automatic win(input logic [8:0] bin, input int nv, input logic mode, input int gap,
                     input logic ej, input logic [4:0] eh, input logic eb);
    exp_t e;
    for (int f = 0; f < 128; f++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_data = bin; i_mode = mode;
      i_mag = (f < nv) ? 16'd2000 : 16'd500;
      chk_s = (f == 127);
      if (f == 127) begin
        if (ej) last_h = eh;
        e.jump = ej;
        e.height = ej ? eh : (HOLD ? last_h : 5'd0);
        e.busy = eb;
        q.push_back(e);
      end else begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          i_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; chk_s = 1'b1;
    e.jump = 1'b0;
    e.height = HOLD ? last_h : 5'd0;
    e.busy = eb;
    q.push_back(e);
    @(posedge clk); #1;
    chk_s = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_initial", {jump, height, o_busy}, 7'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // MAX mode, bin 100 everywhere: (100-32)>>3 = 8
    win(9'd100, 128, 1'b0, 0, 1'b1, 5'd8, 1'b1);
    do_reset();
    // 99 voiced frames: one short of the count threshold
    win(9'd400, 99, 1'b0, 0, 1'b0, 5'd0, 1'b0);
    // exactly 100 voiced frames qualify: (40-32)>>3 = 1
    win(9'd40, 100, 1'b0, 0, 1'b1, 5'd1, 1'b1);
    do_reset();
    // metric one below the threshold, then exactly at it (height 0)
    win(9'd31, 128, 1'b0, 0, 1'b0, 5'd0, 1'b0);
    win(9'd32, 128, 1'b0, 0, 1'b1, 5'd0, 1'b1);
    do_reset();
    // AVG: 104*200 = 20800 >> 7 = 162; (162-32)>>3 = 16
    win(9'd200, 104, 1'b1, 0, 1'b1, 5'd16, 1'b1);
    do_reset();
    // MAX: (200-32)>>3 = 21
    win(9'd200, 104, 1'b0, 0, 1'b1, 5'd21, 1'b1);
    do_reset();
    // MAX: (511-32)>>3 = 59 saturates to 31
    win(9'd511, 104, 1'b0, 0, 1'b1, 5'd31, 1'b1);
    do_reset();

    // Four qualifying windows: jump, masked, masked (cooldown ends), jump
    win(9'd100, 128, 1'b0, 0, 1'b1, 5'd8, 1'b1);
    win(9'd100, 128, 1'b0, 0, 1'b0, 5'd0, 1'b1);
    win(9'd100, 128, 1'b0, 0, 1'b0, 5'd0, 1'b0);
    win(9'd100, 128, 1'b0, 0, 1'b1, 5'd8, 1'b1);

    // Sparse frames, reset during cooldown at frame 60, then a full fresh window
    frames(9'd100, 60, 2);
    check("busy_before_reset", {6'd0, o_busy}, 7'd1);
    do_reset();
    win(9'd100, 128, 1'b0, 2, 1'b1, 5'd8, 1'b1);

    repeat (4) @(posedge clk);
    check("queue_drained", 7'(q.size()), 7'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
